alu_dispatcher: RTL and testbench
=================================

ALU_DISPATCHER -- requirements
Module: alu_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port en, input, 1: clock enable; when low, all state SHALL hold.
REQ-005 SHALL have port start, input, 1: request to begin an operation.
REQ-006 SHALL have port op, input, 2: operation select; 0=ADD, 1=SUB, 2=MUL, 3=NEG.
REQ-007 SHALL have ports value1 and value2, input, WIDTH each: operands; NEG uses value1 only.
REQ-008 SHALL have ports Output1 and Output2, output, WIDTH each: result low half and result high half.
REQ-009 SHALL have port ready, output, 1: one-cycle pulse marking a valid new result.
REQ-010 SHALL have port busy, output, 1: high while an operation is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, MULT and DONE; DONE lasts one cycle, then returns to IDLE.
REQ-012 SHALL accept start only when en=1 and state=IDLE; on acceptance, SHALL latch op, value1 and value2, so later operand changes have no effect.
REQ-013 SHALL ignore start while busy=1; the request is dropped, not queued.
REQ-014 SHALL drive busy high in CALC and MULT, and low in IDLE and DONE.
REQ-015 ADD, SUB and NEG SHALL go IDLE->CALC->DONE: for a start accepted at edge k, ready SHALL be high during the cycle after edge k+2.
REQ-016 ADD SHALL produce Output1 = (value1+value2) mod 2^WIDTH.
REQ-017 SUB SHALL produce Output1 = (value1+~value2+1) mod 2^WIDTH.
REQ-018 NEG SHALL produce Output1 = (~value1+1) mod 2^WIDTH; NEG of the most-negative value SHALL return that same value.
REQ-019 SHALL drive Output2 = 0 for ADD, SUB and NEG.
REQ-020 MUL SHALL compute the signed two's-complement product by radix-2 Booth recoding, one bit per cycle, for exactly WIDTH cycles in MULT.
REQ-021 MUL result SHALL be placed as {Output2,Output1} = 2*WIDTH-bit product; ready SHALL be high during the cycle after edge k+WIDTH+1.
REQ-022 Output1 and Output2 SHALL update only on entry to DONE and SHALL hold until the next result.
REQ-023 When en=0 in any state, SHALL freeze state, the iteration counter and the outputs; a ready pulse SHALL stretch for as long as en stays low in DONE.
REQ-024 A start arriving in the same cycle as DONE SHALL be ignored; start is first accepted in the following IDLE cycle.

Reset
REQ-025 On rst_n=0, SHALL go to IDLE immediately, regardless of clk or en.
REQ-026 During reset, Output1, Output2, ready, busy and all flags SHALL be 0.
REQ-027 Reset during CALC or MULT SHALL abort the operation with no ready pulse.
REQ-028 SHALL first accept start on the first rising edge with rst_n=1.

Configuration
REQ-029 With macro ALU_DISPATCHER_FLAGS_EN defined, SHALL add output ports c_out, zero and ovf, each 1 bit, registered with the result.
REQ-030 c_out SHALL be the carry out of the ADD or SUB adder, and 0 for MUL and NEG.
REQ-031 zero SHALL be 1 when the full result is all zeros ({Output2,Output1} for MUL).
REQ-032 ovf SHALL flag signed overflow for ADD, SUB and NEG, and SHALL be 1 for MUL when the product does not fit in WIDTH signed bits.
REQ-033 Without the macro, the flag ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-034 ADD 100+27 -> Output1=127, Output2=0, ready 2 cycles after start, busy high 1 cycle; flags c_out=0, zero=0, ovf=0.
REQ-035 SUB 5-7 -> Output1=0xFE, c_out=0; SUB 0x80-0x01 -> Output1=0x7F, ovf=1.
REQ-036 MUL -3*5 -> {Output2,Output1}=0xFFF1, ready exactly 9 cycles after start; MUL 0x80*0x80 -> 0x4000, ovf=1.
REQ-037 NEG 0x80 -> Output1=0x80, ovf=1; NEG 0 -> Output1=0, zero=1.
REQ-038 Start MUL 7*7, pulse start with ADD after 3 cycles, hold en=0 for 4 cycles mid-MUL -> ADD ignored, result 49, ready delayed by exactly 4 cycles.
REQ-039 Drop rst_n in MULT cycle 5 -> outputs 0 at once, no ready; start after release -> normal 9-cycle MUL.

Source files
------------

// File: rtl/alu_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : alu_dispatcher
//  Purpose  : Multi-cycle ALU dispatcher. ADD, SUB and NEG finish in one CALC
//             cycle. MUL is a signed radix-2 Booth multiplier that resolves
//             one bit per cycle for WIDTH cycles. Results are presented for
//             one DONE cycle, which is marked by ready.
//  Options  : ALU_DISPATCHER_FLAGS_EN adds the registered result flags
//             c_out, zero and ovf.
//  Revision : 1.0  initial release
// ============================================================================
module alu_dispatcher #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic [WIDTH-1:0] Output1,
    output logic [WIDTH-1:0] Output2,
    output logic             ready,
    output logic             busy
`ifdef ALU_DISPATCHER_FLAGS_EN
    ,
    output logic             c_out,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_MULT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_v1;
    logic [WIDTH-1:0] r_v2;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH:0]   r_acc;     // Booth partial product, one guard bit
    logic [WIDTH-1:0] r_q;       // multiplier, shifted out as bits retire
    logic             r_qm1;     // Booth q(-1) bit
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_neg;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_bsum;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_last;

    // Single-cycle arithmetic on the latched operands; carries kept for flags
    assign w_add = {1'b0, r_v1} + {1'b0, r_v2};
    assign w_sub = {1'b0, r_v1} + {1'b0, ~r_v2} + {{WIDTH{1'b0}}, 1'b1};
    assign w_neg = ~r_v1 + {{(WIDTH-1){1'b0}}, 1'b1};

    // Select the CALC result for the latched operation
    always_comb begin
        w_res = w_neg;
        case (r_op)
            OP_ADD:  w_res = w_add[WIDTH-1:0];
            OP_SUB:  w_res = w_sub[WIDTH-1:0];
            default: w_res = w_neg;
        endcase
    end

    // The guard bit keeps A - M exact when M is the most-negative value
    assign w_m_ext = {r_v2[WIDTH-1], r_v2};

    // Booth add/subtract step selected by the multiplier bit pair
    always_comb begin
        w_bsum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_bsum = r_acc + w_m_ext;
            2'b10:   w_bsum = r_acc - w_m_ext;
            default: w_bsum = r_acc;
        endcase
    end

    // Arithmetic right shift of {acc, q}; w_prod is the product after this step
    assign w_acc_nxt = {w_bsum[WIDTH], w_bsum[WIDTH:1]};
    assign w_q_nxt   = {w_bsum[0], r_q[WIDTH-1:1]};
    assign w_prod    = {w_acc_nxt[WIDTH-1:0], w_q_nxt};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_DISPATCHER_FLAGS_EN
    logic r_cout;
    logic r_zero;
    logic r_ovf;
    logic w_cout_c;
    logic w_ovf_c;
    logic w_ovf_m;

    // Carry and signed overflow of the single-cycle operations
    always_comb begin
        w_cout_c = 1'b0;
        w_ovf_c  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_cout_c = w_add[WIDTH];
                w_ovf_c  = (r_v1[WIDTH-1] == r_v2[WIDTH-1]) &&
                           (w_add[WIDTH-1] != r_v1[WIDTH-1]);
            end
            OP_SUB: begin
                w_cout_c = w_sub[WIDTH];
                w_ovf_c  = (r_v1[WIDTH-1] != r_v2[WIDTH-1]) &&
                           (w_sub[WIDTH-1] != r_v1[WIDTH-1]);
            end
            default: begin
                // Only the most-negative value fails to negate
                w_ovf_c  = r_v1[WIDTH-1] & w_neg[WIDTH-1];
            end
        endcase
    end

    // Product fits in WIDTH signed bits only if the top WIDTH+1 bits agree
    assign w_ovf_m = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

    assign c_out = r_cout;
    assign zero  = r_zero;
    assign ovf   = r_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = &{1'b0, w_add[WIDTH], w_sub[WIDTH]};
`endif

    // Control FSM, operand capture, Booth iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_v1    <= '0;
            r_v2    <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
`ifdef ALU_DISPATCHER_FLAGS_EN
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_v1    <= value1;
                        r_v2    <= value2;
                        r_acc   <= '0;
                        r_q     <= value1;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= (op == OP_MUL) ? S_MULT : S_CALC;
                    end
                end
                S_CALC: begin
                    r_lo    <= w_res;
                    r_hi    <= '0;
`ifdef ALU_DISPATCHER_FLAGS_EN
                    r_cout  <= w_cout_c;
                    r_zero  <= ~|w_res;
                    r_ovf   <= w_ovf_c;
`endif
                    r_state <= S_DONE;
                end
                S_MULT: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_lo    <= w_prod[WIDTH-1:0];
                        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
`ifdef ALU_DISPATCHER_FLAGS_EN
                        r_cout  <= 1'b0;
                        r_zero  <= ~|w_prod;
                        r_ovf   <= w_ovf_m;
`endif
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Output1 = r_lo;
    assign Output2 = r_hi;
    assign ready   = (r_state == S_DONE);
    assign busy    = (r_state == S_CALC) || (r_state == S_MULT);

endmodule
`default_nettype wire

// File: tb/tb_alu_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_dispatcher
//  Purpose  : Scoreboard bench for alu_dispatcher (WIDTH=8). Stimulus pushes
//             hand-computed results and ready cycles; a monitor pops and
//             compares on every rising ready. Flags are checked when
//             ALU_DISPATCHER_FLAGS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_dispatcher;

    localparam int W = 8;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_NEG = 2'd3;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] value1;
    logic [W-1:0] value2;
    logic [W-1:0] Output1;
    logic [W-1:0] Output2;
    logic         ready;
    logic         busy;
`ifdef ALU_DISPATCHER_FLAGS_EN
    logic         c_out;
    logic         zero;
    logic         ovf;
`endif

    alu_dispatcher #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (start),
        .op      (op),
        .value1  (value1),
        .value2  (value2),
        .Output1 (Output1),
        .Output2 (Output2),
        .ready   (ready),
        .busy    (busy)
`ifdef ALU_DISPATCHER_FLAGS_EN
        ,
        .c_out   (c_out),
        .zero    (zero),
        .ovf     (ovf)
`endif
    );

    typedef struct {
        string        nm;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    logic ready_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every new ready pulse is matched against the scoreboard head
    always @(negedge clk) begin
        if (!rst_n) begin
            ready_q = 1'b0;
        end else begin
            if (ready && !ready_q) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_ready: got ready at cycle %0d expected none (Output1=%0h)", cyc, Output1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk({e.nm, "_lo"},  Output1, e.lo);
                    chk({e.nm, "_hi"},  Output2, e.hi);
                    chk({e.nm, "_cyc"}, cyc,     e.cyc);
`ifdef ALU_DISPATCHER_FLAGS_EN
                    chk({e.nm, "_cout"}, c_out, e.c);
                    chk({e.nm, "_zero"}, zero,  e.z);
                    chk({e.nm, "_ovf"},  ovf,   e.v);
`endif
                end
            end
            ready_q = ready;
        end
    end

    // Called at a negedge with the DUT idle; returns one cycle after acceptance
    task automatic issue(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic ec, input logic ez, input logic ev, input int extra);
        exp_t e;
        op     = o;
        value1 = a;
        value2 = b;
        start  = 1'b1;
        e.nm  = nm;
        e.lo  = elo;
        e.hi  = ehi;
        e.c   = ec;
        e.z   = ez;
        e.v   = ev;
        e.cyc = cyc + ((o == OP_MUL) ? (W + 1) : 2) + extra;
        sbq.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        // Scramble operands after acceptance; the latched copies must be used
        value1 = W'($urandom);
        value2 = W'($urandom);
        op     = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            nvec++;
            nerr++;
            $display("FAIL idle_timeout: got busy=%0b ready=%0b expected idle", busy, ready);
        end
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                       input logic ec, input logic ez, input logic ev);
        issue(nm, o, a, b, elo, ehi, ec, ez, ev, 0);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        en     = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        value1 = '0;
        value2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_out1",  Output1, 0);
        chk("rst_out2",  Output2, 0);
        chk("rst_ready", ready,   0);
        chk("rst_busy",  busy,    0);

        // Start presented together with reset release: accepted on first edge
        rst_n = 1'b1;
        issue("add_100_27", OP_ADD, 8'd100, 8'd27, 8'd127, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        chk("add_busy_calc", busy, 1);
        @(negedge clk);
        chk("add_busy_done", busy, 0);
        wait_idle();

        run("sub_5_7",     OP_SUB, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
        run("sub_80_01",   OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1);
        run("add_ff_01",   OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        run("mul_m3_5",    OP_MUL, 8'hFD, 8'h05, 8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0);
        run("mul_80_80",   OP_MUL, 8'h80, 8'h80, 8'h00, 8'h40, 1'b0, 1'b0, 1'b1);
        run("mul_7f_7f",   OP_MUL, 8'h7F, 8'h7F, 8'h01, 8'h3F, 1'b0, 1'b0, 1'b1);
        run("neg_80",      OP_NEG, 8'h80, 8'h55, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
        run("neg_00",      OP_NEG, 8'h00, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Start raised during DONE must be ignored
        issue("add_3_4", OP_ADD, 8'd3, 8'd4, 8'd7, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        op     = OP_ADD;
        value1 = 8'd9;
        value2 = 8'd9;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_idle();

        // MUL 7*7, ADD pulse while busy, then en low for 4 cycles mid-MUL
        issue("mul_7_7_en", OP_MUL, 8'd7, 8'd7, 8'd49, 8'h00, 1'b0, 1'b0, 1'b0, 4);
        repeat (2) @(negedge clk);
        op     = OP_ADD;
        value1 = 8'd1;
        value2 = 8'd1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        en     = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_low_busy_hold", busy, 1);
        en     = 1'b1;
        wait_idle();

        // Reset in MULT cycle 5 aborts with outputs cleared at once
        op     = OP_MUL;
        value1 = 8'h7F;
        value2 = 8'h7F;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out1",  Output1, 0);
        chk("abort_out2",  Output2, 0);
        chk("abort_ready", ready,   0);
        chk("abort_busy",  busy,    0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("mul_12_m10", OP_MUL, 8'h0C, 8'hF6, 8'h88, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
        wait_idle();

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            nvec++;
            nerr++;
            $display("FAIL %s_missing: got no ready expected ready at cycle %0d", e.nm, e.cyc);
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
